// File: rtl/rr_mux_arbiter_pkg.sv
// Shared types and sizing helpers for the round-robin packet arbiter.
package rr_mux_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  // Watchdog counter width; TIMEOUT must not exceed 2**TMO_CNT_W.
  localparam int TMO_CNT_W = 16;

  function automatic int sel_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_mux_arbiter_rr_pick.sv
// Round-robin winner search: first requester at or after ptr, wrapping.
module rr_pick
  import rr_mux_arbiter_pkg::*;
#(
  parameter  int N     = 4,
  localparam int SEL_W = sel_w(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [2*N-1:0] req2;
  logic [2*N-1:0] mask;
  logic [2*N-1:0] masked;

  // The doubled request vector turns the wrap-around into a linear scan.
  always_comb begin
    req2   = {req, req};
    mask   = '0;
    for (int j = 0; j < 2*N; j++) begin
      mask[j] = (j >= int'(ptr)) && (j < int'(ptr) + N);
    end
    masked = req2 & mask;
    found  = 1'b0;
    idx    = '0;
    for (int j = 2*N-1; j >= 0; j--) begin
      if (masked[j]) begin
        found = 1'b1;
        idx   = SEL_W'((j >= N) ? j - N : j);
      end
    end
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// N:1 packet-granular round-robin arbiter driving a shared data mux, with watchdog.
module rr_mux_arbiter
  import rr_mux_arbiter_pkg::*;
#(
  parameter  int N       = 4,
  parameter  int DATA_W  = 8,
  parameter  int TIMEOUT = 16,
  localparam int SEL_W   = sel_w(N)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N-1:0]        in_valid,
  input  logic [N*DATA_W-1:0] in_data,
  input  logic [N-1:0]        in_last,
  output logic [N-1:0]        in_ready,
  output logic                out_valid,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_last,
  input  logic                out_ready,
  output logic [SEL_W-1:0]    sel,
  output logic                busy,
  output logic                timeout_err
);

  arb_state_t           state;
  logic [SEL_W-1:0]     ptr;
  logic [SEL_W-1:0]     next_ptr;
  logic [SEL_W-1:0]     pick_idx;
  logic                 pick_found;
  logic [TMO_CNT_W-1:0] wdog_cnt;
  logic                 owner_valid;
  logic                 owner_last;
  logic [DATA_W-1:0]    owner_data;
  logic                 xfer;
  logic                 release_last;
  logic                 wdog_fire;

  rr_pick #(.N(N)) u_pick (
    .req   (in_valid),
    .ptr   (ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    owner_valid = 1'b0;
    owner_last  = 1'b0;
    owner_data  = '0;
    for (int i = 0; i < N; i++) begin
      if (SEL_W'(i) == sel) begin
        owner_valid = in_valid[i];
        owner_last  = in_last[i];
        owner_data  = in_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign busy      = (state == BUSY);
  assign out_valid = busy & owner_valid;
  assign out_last  = busy & owner_last;
  assign out_data  = busy ? owner_data : '0;

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N; i++) begin
      in_ready[i] = busy && out_ready && (SEL_W'(i) == sel);
    end
  end

  assign xfer         = out_valid & out_ready;
  assign release_last = xfer & out_last;
  // A last-beat transfer always wins over the watchdog since firing requires no transfer.
  assign wdog_fire    = (TIMEOUT > 0) && busy && !xfer &&
                        (wdog_cnt == TMO_CNT_W'(TIMEOUT - 1));
  assign next_ptr     = (sel == SEL_W'(N - 1)) ? '0 : sel + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      sel         <= '0;
      ptr         <= '0;
      wdog_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= wdog_fire;
      case (state)
        IDLE: begin
          if (pick_found) begin
            state    <= BUSY;
            sel      <= pick_idx;
            wdog_cnt <= '0;
          end
        end
        BUSY: begin
          if (release_last || wdog_fire) begin
            state    <= IDLE;
            ptr      <= next_ptr;
            wdog_cnt <= '0;
          end else if (xfer) begin
            wdog_cnt <= '0;
          end else if (TIMEOUT > 0) begin
            wdog_cnt <= wdog_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
